serializador: RTL and testbench

SERIALIZADOR -- requirements
Module: serializador

---
 rtl/serializador.sv | 171 +++++++++++++++++
 tb/tb_serializador.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serializador.sv
// -----------------------------------------------------------------------------
// serializador
//
// Parallel-to-serial transmitter. A word accepted on load is sent as a frame
// on tx: one low start bit, PARAM_BITS data bits LSB first, and one high stop
// bit. Each bit is held for CLKS_PER_BIT clock cycles. The line idles high.
//
// Parameters
//   PARAM_BITS    data word width in bits (>= 1)
//   CLKS_PER_BIT  clock cycles per serial bit period (>= 1)
//
// Ports
//   clk      system clock; all state changes on the rising edge
//   rst_n    asynchronous active-low reset; aborts any frame in progress
//   data_in  parallel word, captured on the accepting edge
//   load     send request; only looked at while ready is high
//   ready    high when a new word can be accepted (idle state only)
//   busy     high while a frame is being driven on tx
//   tx       registered serial output, high when idle
//   done     single-cycle pulse in the first idle cycle after a frame
// -----------------------------------------------------------------------------
module serializador #(
    parameter int PARAM_BITS   = 9,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PARAM_BITS-1:0] data_in,
    input  logic                  load,
    output logic                  ready,
    output logic                  busy,
    output logic                  tx,
    output logic                  done
);

    // Counter widths: ceil(log2(n)) with a floor of one bit so the degenerate
    // single-bit / single-cycle configurations still have a legal register.
    localparam int BIT_W = (PARAM_BITS > 1) ? $clog2(PARAM_BITS) : 1;
    localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PARAM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                  state_r;
    logic [CYC_W-1:0]        cyc_cnt_r;
    logic [BIT_W-1:0]        bit_cnt_r;
    logic [PARAM_BITS-1:0]   shift_r;

    logic                    period_end_s;
    logic [BIT_W-1:0]        bit_next_s;

    // Return bit idx of word. An index beyond the top of the word reads as 0;
    // that only happens on the last data bit, where the value is not used.
    function automatic logic select_bit(input logic [PARAM_BITS-1:0] word,
                                        input logic [BIT_W-1:0]      idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < PARAM_BITS; i++) begin
            if (idx == BIT_W'(i)) begin
                b = word[i];
            end
        end
        return b;
    endfunction

    // Last cycle of the current bit period: the cycle counter wraps here.
    assign period_end_s = (cyc_cnt_r == CYC_LAST);

    // Index of the data bit that follows the one currently on the line.
    assign bit_next_s = bit_cnt_r + BIT_W'(1);

    // Frame sequencer: state, counters, captured word and every output.
    // tx is loaded one edge ahead of each period so that it is already
    // settled for the whole period it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cyc_cnt_r <= {CYC_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            shift_r   <= {PARAM_BITS{1'b0}};
            tx        <= 1'b1;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // done is high only in the cycle right after the STOP period.
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    cyc_cnt_r <= {CYC_W{1'b0}};
                    bit_cnt_r <= {BIT_W{1'b0}};
                    if (load) begin
                        // Word is frozen here; later data_in changes are ignored.
                        shift_r <= data_in;
                        state_r <= START;
                        tx      <= 1'b0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        shift_r <= shift_r;
                        state_r <= IDLE;
                        tx      <= 1'b1;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end
                end

                START: begin
                    if (period_end_s) begin
                        cyc_cnt_r <= {CYC_W{1'b0}};
                        bit_cnt_r <= {BIT_W{1'b0}};
                        state_r   <= DATA;
                        tx        <= select_bit(shift_r, {BIT_W{1'b0}});
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                    end
                end

                DATA: begin
                    if (period_end_s) begin
                        cyc_cnt_r <= {CYC_W{1'b0}};
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_next_s;
                            tx        <= select_bit(shift_r, bit_next_s);
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                    end
                end

                STOP: begin
                    if (period_end_s) begin
                        // Back to IDLE with ready already high, so a load in
                        // the done cycle starts the next frame immediately.
                        cyc_cnt_r <= {CYC_W{1'b0}};
                        bit_cnt_r <= {BIT_W{1'b0}};
                        state_r   <= IDLE;
                        tx        <= 1'b1;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean idle line.
                    state_r   <= IDLE;
                    cyc_cnt_r <= {CYC_W{1'b0}};
                    bit_cnt_r <= {BIT_W{1'b0}};
                    shift_r   <= {PARAM_BITS{1'b0}};
                    tx        <= 1'b1;
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializador.sv
// -----------------------------------------------------------------------------
// tb_serializador
//
// Two instances of serializador (9 data bits; 4 and 1 clocks per bit).
// Stimulus tasks drive load/data_in and, using a simple "busy until edge N"
// model of the block, push every word that must be accepted into a queue
// together with its capture edge. A monitor per instance records tx while
// busy is high and, on each done pulse, pops the oldest expected word and
// compares the recorded line against the frame built from the word.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serializador;

    localparam int NB = 9;
    localparam int C0 = 4;
    localparam int C1 = 1;

    typedef struct packed {
        logic [NB-1:0] word;
        int            cap;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges so far; read only at falling edges.
    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    logic          rst0_n, load0, ready0, busy0, tx0, done0;
    logic [NB-1:0] data0;
    logic          rst1_n, load1, ready1, busy1, tx1, done1;
    logic [NB-1:0] data1;

    serializador #(.PARAM_BITS(NB), .CLKS_PER_BIT(C0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .data_in(data0), .load(load0),
        .ready(ready0), .busy(busy0), .tx(tx0), .done(done0));

    serializador #(.PARAM_BITS(NB), .CLKS_PER_BIT(C1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .data_in(data1), .load(load1),
        .ready(ready1), .busy(busy1), .tx(tx1), .done(done1));

    int n_checks = 0;
    int n_fail   = 0;

    frame_t      q0[$];
    frame_t      q1[$];
    int          ready_from[2];
    logic [63:0] col[2];
    int          col_len[2];
    int          col_start[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cpb(input int d);
        return (d == 0) ? C0 : C1;
    endfunction

    // Whole frame as the line should show it, one bit per clock, oldest first.
    function automatic logic [63:0] exp_frame(input logic [NB-1:0] w, input int c);
        logic [63:0] v;
        logic        b;
        v = 64'd0;
        for (int j = 0; j < NB + 2; j++) begin
            if (j == 0)       b = 1'b0;
            else if (j <= NB) b = w[j-1];
            else              b = 1'b1;
            for (int r = 0; r < c; r++) v = {v[62:0], b};
        end
        return v;
    endfunction

    // Monitor step for one instance, called at every falling edge.
    task automatic mon(input int d, input logic rn, input logic t,
                       input logic bsy, input logic rdy, input logic dn);
        int     fl;
        frame_t f;
        int     qs;
        fl = (NB + 2) * cpb(d);
        if (!rn) begin
            check($sformatf("in_reset_outputs_%0d", d), {t, rdy, bsy, dn}, 4'b1100);
            col_len[d] = 0;
            col[d]     = 64'd0;
            if (d == 0) q0.delete(); else q1.delete();
        end else begin
            if (bsy) begin
                if (col_len[d] == 0) col_start[d] = ecnt;
                col[d] = {col[d][62:0], t};
                col_len[d]++;
                if (col_len[d] == fl + 1)
                    check($sformatf("frame_overrun_%0d", d), col_len[d], fl);
            end else begin
                check($sformatf("idle_tx_high_%0d", d), t, 1'b1);
            end
            if (dn) begin
                qs = (d == 0) ? q0.size() : q1.size();
                if (qs == 0) begin
                    check($sformatf("done_without_frame_%0d", d), qs, 1);
                end else begin
                    f = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("frame_len_%0d", d), col_len[d], fl);
                    check($sformatf("frame_bits_%0d_w%0h", d, f.word), col[d], exp_frame(f.word, cpb(d)));
                    check($sformatf("busy_start_%0d", d), col_start[d], f.cap);
                    check($sformatf("done_latency_%0d", d), ecnt - f.cap, fl);
                    check($sformatf("ready_at_done_%0d", d), rdy, 1'b1);
                    check($sformatf("busy_at_done_%0d", d), bsy, 1'b0);
                end
                col_len[d] = 0;
                col[d]     = 64'd0;
            end
        end
    endtask

    always @(negedge clk) mon(0, rst0_n, tx0, busy0, ready0, done0);
    always @(negedge clk) mon(1, rst1_n, tx1, busy1, ready1, done1);

    // Drive one cycle of inputs; the model decides whether the coming edge accepts.
    task automatic drive(input int d, input logic ld, input logic [NB-1:0] w);
        frame_t f;
        @(negedge clk);
        if (d == 0) begin load0 = ld; data0 = w; end
        else        begin load1 = ld; data1 = w; end
        if (ld && (ecnt + 1) >= ready_from[d]) begin
            f.word = w;
            f.cap  = ecnt + 1;
            if (d == 0) q0.push_back(f); else q1.push_back(f);
            ready_from[d] = ecnt + 1 + (NB + 2) * cpb(d) + 1;
        end
    endtask

    // Idle the inputs until the model says the last frame (and its done) is over.
    task automatic wait_idle(input int d);
        while (ecnt < ready_from[d]) drive(d, 1'b0, NB'($urandom));
        drive(d, 1'b0, NB'($urandom));
    endtask

    // Assert reset part-way through a cycle and check the outputs at once.
    task automatic do_reset(input int d);
        @(posedge clk);
        #2;
        if (d == 0) rst0_n = 1'b0; else rst1_n = 1'b0;
        #1;
        if (d == 0) check("async_reset_0", {tx0, ready0, busy0, done0}, 4'b1100);
        else        check("async_reset_1", {tx1, ready1, busy1, done1}, 4'b1100);
        repeat (2) @(negedge clk);
        #1;
        if (d == 0) begin rst0_n = 1'b1; load0 = 1'b0; end
        else        begin rst1_n = 1'b1; load1 = 1'b0; end
        ready_from[d] = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cap;
        logic [NB-1:0] w;
        rst0_n = 1'b1; rst1_n = 1'b1;
        load0 = 1'b0; load1 = 1'b0;
        data0 = '0; data1 = '0;
        ready_from[0] = 0; ready_from[1] = 0;
        for (int i = 0; i < 2; i++) begin col[i] = 64'd0; col_len[i] = 0; col_start[i] = 0; end

        do_reset(0);
        do_reset(1);

        // Single frame 9'h1A5.
        drive(0, 1'b1, 9'h1A5);
        wait_idle(0);

        // Load of 9'h0FF during the data bits of a 9'h1A5 frame is ignored.
        drive(0, 1'b1, 9'h1A5);
        repeat (10) drive(0, 1'b0, 9'h000);
        repeat (6)  drive(0, 1'b1, 9'h0FF);
        wait_idle(0);

        // Back-to-back: load held high, data switched to 9'h003 in the done cycle.
        drive(0, 1'b1, 9'h1A5);
        while (ecnt + 2 < ready_from[0]) drive(0, 1'b1, 9'h1A5);
        drive(0, 1'b1, 9'h003);
        wait_idle(0);

        // Reset during data bit 4, then a clean 9'h155 frame.
        w = 9'h1A5;
        drive(0, 1'b1, w);
        cap = ecnt + 1;
        while (ecnt < cap + 5 * C0 + 1) drive(0, 1'b0, 9'h000);
        check("tx_bit4_before_reset", tx0, w[4]);
        do_reset(0);
        drive(0, 1'b1, 9'h155);
        wait_idle(0);

        // Random traffic: sparse loads, data churning while busy.
        for (int i = 0; i < 700; i++)
            drive(0, ($urandom_range(0, 3) == 0), NB'($urandom));
        wait_idle(0);

        // One clock per bit.
        drive(1, 1'b1, 9'h000);
        wait_idle(1);
        drive(1, 1'b1, 9'h1FF);
        wait_idle(1);
        drive(1, 1'b1, 9'h0A5);
        while (ecnt + 2 < ready_from[1]) drive(1, 1'b1, 9'h0A5);
        drive(1, 1'b1, 9'h15A);
        wait_idle(1);
        for (int i = 0; i < 300; i++)
            drive(1, ($urandom_range(0, 2) == 0), NB'($urandom));
        wait_idle(1);

        repeat (3) @(negedge clk);
        check("pending_frames_0", q0.size(), 0);
        check("pending_frames_1", q1.size(), 0);
        check("partial_frame_0", col_len[0], 0);
        check("partial_frame_1", col_len[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
